synverll_sdiv_arb4: RTL and testbench

SYNVERLL_SDIV_ARB4 -- requirements
Module: synverll_sdiv_arb4

---
 rtl/synverll_sdiv_arb4.sv | 184 ++++++++++++++++++
 tb/tb_synverll_sdiv_arb4.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synverll_sdiv_arb4.sv
// Four-requester front end for one shared pipelined signed divider: grants, tags, routes results back.
// Build option: define SYNVERLL_SDIV_ARB_FIXPRI_EN for fixed priority (requester 0 highest) instead of round-robin.
module synverll_sdiv_arb4 #(
    parameter int LATENCY = 34,
    parameter int WIDTH   = 32
) (
    input  logic                    system_clock,
    input  logic                    system_reset,

    input  logic                    req_0,
    input  logic                    req_1,
    input  logic                    req_2,
    input  logic                    req_3,
    output logic                    ready_0,
    output logic                    ready_1,
    output logic                    ready_2,
    output logic                    ready_3,

    input  logic signed [WIDTH-1:0] args0_0,
    input  logic signed [WIDTH-1:0] args1_0,
    input  logic signed [WIDTH-1:0] args0_1,
    input  logic signed [WIDTH-1:0] args1_1,
    input  logic signed [WIDTH-1:0] args0_2,
    input  logic signed [WIDTH-1:0] args1_2,
    input  logic signed [WIDTH-1:0] args0_3,
    input  logic signed [WIDTH-1:0] args1_3,

    output logic                    done_0,
    output logic                    done_1,
    output logic                    done_2,
    output logic                    done_3,
    output logic signed [WIDTH-1:0] q_0,
    output logic signed [WIDTH-1:0] r_0,
    output logic signed [WIDTH-1:0] q_1,
    output logic signed [WIDTH-1:0] r_1,
    output logic signed [WIDTH-1:0] q_2,
    output logic signed [WIDTH-1:0] r_2,
    output logic signed [WIDTH-1:0] q_3,
    output logic signed [WIDTH-1:0] r_3,

    output logic                    div_req,
    output logic signed [WIDTH-1:0] div_args_0,
    output logic signed [WIDTH-1:0] div_args_1,
    input  logic                    div_done,
    input  logic signed [WIDTH-1:0] div_q,
    input  logic signed [WIDTH-1:0] div_r,

    output logic                    err
);

    logic [3:0]              w_req;
    logic [3:0]              w_gnt;
    logic                    w_any;
    logic [1:0]              w_gid;
    logic signed [WIDTH-1:0] w_a0 [4];
    logic signed [WIDTH-1:0] w_a1 [4];

    logic                    r_tag_vld [LATENCY];
    logic [1:0]              r_tag_id  [LATENCY];
    logic                    w_tag_vld;
    logic [1:0]              w_tag_id;
    logic                    w_cap;

    logic [3:0]              r_done_p1;
    logic signed [WIDTH-1:0] r_q_p1 [4];
    logic signed [WIDTH-1:0] r_r_p1 [4];
    logic                    r_err;

`ifndef SYNVERLL_SDIV_ARB_FIXPRI_EN
    logic [1:0]              r_ptr;
    logic [1:0]              w_idx;
`endif

    assign w_req   = {req_3, req_2, req_1, req_0};
    assign w_a0[0] = args0_0;
    assign w_a0[1] = args0_1;
    assign w_a0[2] = args0_2;
    assign w_a0[3] = args0_3;
    assign w_a1[0] = args1_0;
    assign w_a1[1] = args1_1;
    assign w_a1[2] = args1_2;
    assign w_a1[3] = args1_3;

    // Scan from lowest to highest priority so the last match seen is the winner.
    always_comb begin
        w_any = 1'b0;
        w_gid = 2'd0;
`ifdef SYNVERLL_SDIV_ARB_FIXPRI_EN
        for (int k = 3; k >= 0; k--) begin
            if (w_req[k]) begin
                w_any = 1'b1;
                w_gid = 2'(k);
            end
        end
`else
        w_idx = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_req[w_idx]) begin
                w_any = 1'b1;
                w_gid = w_idx;
            end
        end
`endif
    end

    assign w_gnt      = w_any ? (4'b0001 << w_gid) : 4'b0000;
    assign ready_0    = w_gnt[0];
    assign ready_1    = w_gnt[1];
    assign ready_2    = w_gnt[2];
    assign ready_3    = w_gnt[3];

    assign div_req    = w_any;
    assign div_args_0 = w_any ? w_a0[w_gid] : '0;
    assign div_args_1 = w_any ? w_a1[w_gid] : '0;

`ifndef SYNVERLL_SDIV_ARB_FIXPRI_EN
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            r_ptr <= 2'd3;
        end else if (w_any) begin
            r_ptr <= w_gid;
        end
    end
`endif

    // Issue stage: tag travels alongside the divider pipeline, one slot per cycle.
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= 2'd0;
            end
        end else begin
            r_tag_vld[0] <= w_any;
            r_tag_id[0]  <= w_gid;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    assign w_tag_vld = r_tag_vld[LATENCY-1];
    assign w_tag_id  = r_tag_id[LATENCY-1];
    assign w_cap     = w_tag_vld & div_done;

    // Return stage: capture divider result into the owning requester's slot.
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            r_done_p1 <= 4'b0000;
            r_err     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_q_p1[k] <= '0;
                r_r_p1[k] <= '0;
            end
        end else begin
            r_done_p1 <= 4'b0000;
            if (w_cap) begin
                r_done_p1[w_tag_id] <= 1'b1;
                r_q_p1[w_tag_id]    <= div_q;
                r_r_p1[w_tag_id]    <= div_r;
            end
            if (w_tag_vld != div_done) begin
                r_err <= 1'b1;
            end
        end
    end

    assign done_0 = r_done_p1[0];
    assign done_1 = r_done_p1[1];
    assign done_2 = r_done_p1[2];
    assign done_3 = r_done_p1[3];
    assign q_0    = r_q_p1[0];
    assign r_0    = r_r_p1[0];
    assign q_1    = r_q_p1[1];
    assign r_1    = r_r_p1[1];
    assign q_2    = r_q_p1[2];
    assign r_2    = r_r_p1[2];
    assign q_3    = r_q_p1[3];
    assign r_3    = r_r_p1[3];
    assign err    = r_err;

endmodule

// File: tb/tb_synverll_sdiv_arb4.sv
// Bench for synverll_sdiv_arb4: divider model, scoreboard monitor, vector table and directed sequences.
module tb_synverll_sdiv_arb4;
    localparam int LAT = 34;
    localparam int W   = 32;

    logic system_clock = 1'b0;
    logic system_reset = 1'b0;
    always #5 system_clock = ~system_clock;

    logic [3:0]          req;
    logic signed [W-1:0] a0 [4];
    logic signed [W-1:0] a1 [4];

    wire rdy0, rdy1, rdy2, rdy3, dn0, dn1, dn2, dn3;
    wire signed [W-1:0] qo0, qo1, qo2, qo3, ro0, ro1, ro2, ro3;
    wire div_req_w, err_w;
    wire signed [W-1:0] dargs0, dargs1;

    logic                real_done = 1'b0;
    logic                force_done = 1'b0;
    logic                div_done_t;
    logic signed [W-1:0] div_q_t = '0;
    logic signed [W-1:0] div_r_t = '0;
    assign div_done_t = real_done | force_done;

    wire [3:0] rdy = {rdy3, rdy2, rdy1, rdy0};
    wire [3:0] dn  = {dn3, dn2, dn1, dn0};
    wire signed [W-1:0] qv [4];
    wire signed [W-1:0] rv [4];
    assign qv[0] = qo0; assign qv[1] = qo1; assign qv[2] = qo2; assign qv[3] = qo3;
    assign rv[0] = ro0; assign rv[1] = ro1; assign rv[2] = ro2; assign rv[3] = ro3;

    synverll_sdiv_arb4 #(.LATENCY(LAT), .WIDTH(W)) dut (
        .system_clock(system_clock), .system_reset(system_reset),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
        .ready_0(rdy0), .ready_1(rdy1), .ready_2(rdy2), .ready_3(rdy3),
        .args0_0(a0[0]), .args1_0(a1[0]), .args0_1(a0[1]), .args1_1(a1[1]),
        .args0_2(a0[2]), .args1_2(a1[2]), .args0_3(a0[3]), .args1_3(a1[3]),
        .done_0(dn0), .done_1(dn1), .done_2(dn2), .done_3(dn3),
        .q_0(qo0), .r_0(ro0), .q_1(qo1), .r_1(ro1),
        .q_2(qo2), .r_2(ro2), .q_3(qo3), .r_3(ro3),
        .div_req(div_req_w), .div_args_0(dargs0), .div_args_1(dargs1),
        .div_done(div_done_t), .div_q(div_q_t), .div_r(div_r_t),
        .err(err_w)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Shared divider model: every issued op completes exactly LAT cycles later.
    typedef struct {int issue; logic signed [W-1:0] a; logic signed [W-1:0] b;} dop_t;
    dop_t dq[$];

    always @(posedge system_clock) begin
        if (!system_reset) begin
            dq.delete();
        end else begin
            if (real_done) void'(dq.pop_front());
            if (div_req_w) dq.push_back('{cyc, dargs0, dargs1});
        end
        cyc++;
        #1;
        real_done = 1'b0;
        div_q_t   = '0;
        div_r_t   = '0;
        if (dq.size() > 0 && dq[0].issue + LAT == cyc) begin
            real_done = 1'b1;
            div_q_t   = dq[0].a / dq[0].b;
            div_r_t   = dq[0].a % dq[0].b;
        end
    end

    // Scoreboard: reference arbiter plus queue of expected completions.
    typedef struct {int due; int id; logic signed [W-1:0] q; logic signed [W-1:0] r;} exp_t;
    exp_t eq[$];
    int   ref_last = 3;
    bit   ref_err  = 1'b0;

    always @(negedge system_clock) begin
        int          gid;
        logic [3:0]  eg;
        logic [3:0]  edn;
        bit          exp_tag;
        if (!system_reset) begin
            eq.delete();
            ref_last = 3;
            ref_err  = 1'b0;
            chk("rst_done", longint'(dn), 0);
            chk("rst_err", longint'(err_w), 0);
        end else begin
            gid = -1;
`ifdef SYNVERLL_SDIV_ARB_FIXPRI_EN
            for (int k = 0; k < 4; k++) if (gid < 0 && req[k]) gid = k;
`else
            for (int k = 1; k <= 4; k++) if (gid < 0 && req[(ref_last + k) % 4]) gid = (ref_last + k) % 4;
`endif
            eg = (gid >= 0) ? (4'b0001 << gid) : 4'b0000;
            chk("mon_ready", longint'(rdy), longint'(eg));
            chk("mon_div_req", longint'(div_req_w), (gid >= 0) ? 1 : 0);
            chk("mon_args0", longint'(dargs0), (gid >= 0) ? longint'(a0[gid]) : 0);
            chk("mon_args1", longint'(dargs1), (gid >= 0) ? longint'(a1[gid]) : 0);

            edn = 4'b0000;
            if (eq.size() > 0 && eq[0].due == cyc) begin
                edn[eq[0].id] = 1'b1;
                chk("mon_q", longint'(qv[eq[0].id]), longint'(eq[0].q));
                chk("mon_r", longint'(rv[eq[0].id]), longint'(eq[0].r));
                void'(eq.pop_front());
            end
            chk("mon_done", longint'(dn), longint'(edn));
            chk("mon_err", longint'(err_w), longint'(ref_err));

            exp_tag = (eq.size() > 0 && eq[0].due == cyc + 1);
            if (div_done_t != exp_tag) ref_err = 1'b1;

            if (gid >= 0) begin
                eq.push_back('{cyc + LAT + 1, gid, a0[gid] / a1[gid], a0[gid] % a1[gid]});
                ref_last = gid;
            end
        end
    end

    task automatic step();
        @(posedge system_clock);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 2000 && cyc < target; i++) step();
        chk("wait_cyc", longint'(cyc), longint'(target));
    endtask

    function automatic logic signed [W-1:0] rnd_dvs();
        int v;
        v = int'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) v = -v;
        if (v == -1) v = 1;
        return W'(v);
    endfunction

    task automatic rnd_args();
        for (int i = 0; i < 4; i++) begin
            a0[i] = W'($urandom);
            a1[i] = rnd_dvs();
        end
    endtask

    task automatic do_reset();
        system_reset = 1'b0;
        req = 4'b0000;
        step();
        step();
        system_reset = 1'b1;
    endtask

    task automatic drain();
        req = 4'b0000;
        repeat (LAT + 4) step();
    endtask

    typedef struct packed {logic [3:0] req; logic [3:0] exp_rr; logic [3:0] exp_fp;} vec_t;
    vec_t tbl [10];

    initial begin
        int c0;
        int cnt;
        tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010, 4'b0001};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0001};
        tbl[3] = '{4'b0001, 4'b0001, 4'b0001};
        tbl[4] = '{4'b1000, 4'b1000, 4'b1000};
        tbl[5] = '{4'b1001, 4'b0001, 4'b0001};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[7] = '{4'b0101, 4'b0100, 4'b0001};
        tbl[8] = '{4'b0101, 4'b0001, 4'b0001};
        tbl[9] = '{4'b1110, 4'b0010, 4'b0010};

        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin a0[i] = '0; a1[i] = 1; end
        repeat (3) @(posedge system_clock);
        #1;
        @(negedge system_clock);
        chk("reset_done", longint'(dn), 0);
        chk("reset_err", longint'(err_w), 0);
        chk("reset_q0", longint'(qo0), 0);
        step();
        system_reset = 1'b1;

        // Vector table from a fresh reset: pointer starts at 3.
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            rnd_args();
            @(negedge system_clock);
`ifdef SYNVERLL_SDIV_ARB_FIXPRI_EN
            chk("tbl_ready", longint'(rdy), longint'(tbl[i].exp_fp));
`else
            chk("tbl_ready", longint'(rdy), longint'(tbl[i].exp_rr));
`endif
            step();
        end
        drain();

        // Single op -7/2 on requester 2.
        a0[2] = -7; a1[2] = 2; req = 4'b0100; c0 = cyc;
        @(negedge system_clock);
        chk("single_ready2", longint'(rdy), 4);
        step();
        req = 4'b0000;
        wait_cyc(c0 + LAT);
        @(negedge system_clock);
        chk("single_early", longint'(dn), 0);
        wait_cyc(c0 + LAT + 1);
        @(negedge system_clock);
        chk("single_done", longint'(dn), 4);
        chk("single_q2", longint'(qo2), -3);
        chk("single_r2", longint'(ro2), -1);
        drain();

        // Back-to-back on requester 1.
        a0[1] = 100; a1[1] = 3; req = 4'b0010; c0 = cyc;
        step();
        a0[1] = 50; a1[1] = 5;
        step();
        req = 4'b0000;
        wait_cyc(c0 + LAT + 1);
        @(negedge system_clock);
        chk("b2b_done_a", longint'(dn), 2);
        chk("b2b_q_a", longint'(qo1), 33);
        chk("b2b_r_a", longint'(ro1), 1);
        wait_cyc(c0 + LAT + 2);
        @(negedge system_clock);
        chk("b2b_done_b", longint'(dn), 2);
        chk("b2b_q_b", longint'(qo1), 10);
        chk("b2b_r_b", longint'(ro1), 0);
        drain();

        // All four requesting continuously from reset.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rnd_args();
            @(negedge system_clock);
`ifdef SYNVERLL_SDIV_ARB_FIXPRI_EN
            chk("all4_ready", longint'(rdy), 1);
`else
            chk("all4_ready", longint'(rdy), longint'(4'b0001 << (k % 4)));
`endif
            step();
        end
        drain();

        // Reset with operations in flight: none may complete afterwards.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin rnd_args(); step(); end
        req = 4'b0000;
        repeat (3) step();
        do_reset();
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge system_clock);
            if (dn != 4'b0000) cnt++;
            step();
        end
        chk("inflight_rst_dones", longint'(cnt), 0);
        chk("inflight_rst_err", longint'(err_w), 0);

        // Requesters 0 and 3 held together.
        req = 4'b1001;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            rnd_args();
            @(negedge system_clock);
            if (rdy3) cnt++;
            step();
        end
`ifdef SYNVERLL_SDIV_ARB_FIXPRI_EN
        chk("pair_r3_grants", longint'(cnt), 0);
`else
        chk("pair_r3_grants", longint'(cnt), 6);
`endif
        drain();

        // Randomized traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            req = 4'($urandom_range(0, 15));
            rnd_args();
            step();
        end
        drain();
        chk("drain_empty", longint'(eq.size()), 0);

        // Spurious div_done with no valid tag sets sticky err.
        force_done = 1'b1;
        @(negedge system_clock);
        chk("err_before", longint'(err_w), 0);
        step();
        force_done = 1'b0;
        @(negedge system_clock);
        chk("err_set", longint'(err_w), 1);
        chk("err_no_done", longint'(dn), 0);
        repeat (5) step();
        @(negedge system_clock);
        chk("err_sticky", longint'(err_w), 1);
        step();
        do_reset();
        @(negedge system_clock);
        chk("err_cleared", longint'(err_w), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
